// File: rtl/ps2_kod_siralayici.sv
// ps2_kod_siralayici
// Keyboard controller front end. It deserialises raw PS/2 frames and parses
// the make, break, E0 and E1 prefixes. Each accepted make code is routed as a
// one-cycle registered strobe onto the button channel or the control channel
// of the ASCII translator.
// Optional feature macro: REPEAT_FILTER_EN. When it is defined, typematic
// repeats of the currently held key are suppressed.
module ps2_kod_siralayici #(
    parameter int TIMEOUT_CYC = 200000,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] buton_giris,
    output logic       buton_aktif,
    output logic [7:0] kontrol_giris,
    output logic       kontrol_aktif,
    output logic       hata
);

    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {
        RX_IDLE   = 2'd0,
        RX_DATA   = 2'd1,
        RX_PARITY = 2'd2,
        RX_STOP   = 2'd3
    } rx_state_t;

    typedef enum logic [2:0] {
        D_IDLE      = 3'd0,
        D_EXT       = 3'd1,
        D_BREAK     = 3'd2,
        D_EXT_BREAK = 3'd3,
        D_SKIP      = 3'd4
    } dec_state_t;

    // Odd parity holds when data and parity bit together have an odd number of ones.
    function automatic logic parity_odd_ok(input logic [7:0] d, input logic p);
        return ^{d, p};
    endfunction

    // Scan codes that belong on the translator's control channel.
    function automatic logic is_control(input logic [7:0] code);
        logic r;
        case (code)
            8'h58, 8'h12, 8'h59, 8'h77, 8'h29, 8'h76, 8'h05, 8'h06,
            8'h04, 8'h0C, 8'h03, 8'h0B, 8'h83, 8'h0A, 8'h01, 8'h09,
            8'h78, 8'h07, 8'h0D, 8'h14, 8'h11, 8'h66, 8'h5A: r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    logic [SYNC_STAGES-1:0] clk_sync_r;
    logic [SYNC_STAGES-1:0] data_sync_r;
    logic                   clk_prev_r;
    logic                   clk_cur_s;
    logic                   data_cur_s;
    logic                   fall_s;

    rx_state_t  rx_state_r, rx_state_s;
    logic [2:0] bit_cnt_r;
    logic [7:0] shift_r;
    logic       par_r;
    logic [TO_W-1:0] to_cnt_r;
    logic       timeout_s;
    logic       byte_ok_s;
    logic       frame_err_s;

    dec_state_t dec_state_r, dec_state_s;
    logic [2:0] skip_r, skip_s;
    logic [7:0] held_r, held_s;
    logic       make_s;
    logic       pass_s;
    logic       emit_s;
    logic       ctl_s;

    assign clk_cur_s  = clk_sync_r[SYNC_STAGES-1];
    assign data_cur_s = data_sync_r[SYNC_STAGES-1];
    assign fall_s     = clk_prev_r & ~clk_cur_s;

    // Synchronise the asynchronous PS/2 pins; idle level of both lines is high.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            clk_sync_r  <= {SYNC_STAGES{1'b1}};
            data_sync_r <= {SYNC_STAGES{1'b1}};
            clk_prev_r  <= 1'b1;
        end else begin
            clk_sync_r  <= {clk_sync_r[SYNC_STAGES-2:0], ps2_clk};
            data_sync_r <= {data_sync_r[SYNC_STAGES-2:0], ps2_data};
            clk_prev_r  <= clk_cur_s;
        end
    end

    // Receiver next state, frame-good strobe and frame errors.
    always_comb begin
        rx_state_s  = rx_state_r;
        byte_ok_s   = 1'b0;
        frame_err_s = 1'b0;
        timeout_s   = (rx_state_r != RX_IDLE) && (to_cnt_r == TO_W'(TIMEOUT_CYC));
        if (timeout_s) begin
            rx_state_s = RX_IDLE;
        end else if (fall_s) begin
            case (rx_state_r)
                RX_IDLE: begin
                    if (!data_cur_s) begin
                        rx_state_s = RX_DATA;
                    end else begin
                        rx_state_s = RX_IDLE;
                    end
                end
                RX_DATA: begin
                    if (bit_cnt_r == 3'd7) begin
                        rx_state_s = RX_PARITY;
                    end else begin
                        rx_state_s = RX_DATA;
                    end
                end
                RX_PARITY: rx_state_s = RX_STOP;
                RX_STOP: begin
                    rx_state_s = RX_IDLE;
                    if (data_cur_s && parity_odd_ok(shift_r, par_r)) begin
                        byte_ok_s = 1'b1;
                    end else begin
                        frame_err_s = 1'b1;
                    end
                end
                default: rx_state_s = RX_IDLE;
            endcase
        end else begin
            rx_state_s = rx_state_r;
        end
    end

    // Receiver state register plus bit shifter, parity capture and timeout counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_state_r <= RX_IDLE;
            bit_cnt_r  <= 3'd0;
            shift_r    <= 8'h00;
            par_r      <= 1'b0;
            to_cnt_r   <= '0;
        end else begin
            rx_state_r <= rx_state_s;
            if (fall_s && !timeout_s) begin
                case (rx_state_r)
                    RX_IDLE: bit_cnt_r <= 3'd0;
                    RX_DATA: begin
                        shift_r   <= {data_cur_s, shift_r[7:1]};
                        bit_cnt_r <= bit_cnt_r + 3'd1;
                    end
                    RX_PARITY: par_r <= data_cur_s;
                    default: bit_cnt_r <= 3'd0;
                endcase
            end
            if ((rx_state_r == RX_IDLE) || fall_s) begin
                to_cnt_r <= '0;
            end else if (to_cnt_r != TO_W'(TIMEOUT_CYC)) begin
                to_cnt_r <= to_cnt_r + {{(TO_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // Decoder next state, held-key tracking and make-code selection.
    always_comb begin
        dec_state_s = dec_state_r;
        skip_s      = skip_r;
        held_s      = held_r;
        make_s      = 1'b0;
        if (frame_err_s || timeout_s) begin
            dec_state_s = D_IDLE;
            skip_s      = 3'd0;
        end else if (byte_ok_s) begin
            case (dec_state_r)
                D_IDLE: begin
                    if (shift_r == 8'hF0) begin
                        dec_state_s = D_BREAK;
                    end else if (shift_r == 8'hE0) begin
                        dec_state_s = D_EXT;
                    end else if (shift_r == 8'hE1) begin
                        dec_state_s = D_SKIP;
                        skip_s      = 3'd7;
                    end else begin
                        make_s = 1'b1;
                    end
                end
                D_EXT: begin
                    if (shift_r == 8'hF0) begin
                        dec_state_s = D_EXT_BREAK;
                    end else begin
                        dec_state_s = D_IDLE;
                        make_s      = 1'b1;
                    end
                end
                D_BREAK, D_EXT_BREAK: begin
                    dec_state_s = D_IDLE;
                    if (shift_r == held_r) begin
                        held_s = 8'h00;
                    end else begin
                        held_s = held_r;
                    end
                end
                D_SKIP: begin
                    if (skip_r <= 3'd1) begin
                        dec_state_s = D_IDLE;
                        skip_s      = 3'd0;
                    end else begin
                        skip_s = skip_r - 3'd1;
                    end
                end
                default: dec_state_s = D_IDLE;
            endcase
        end else begin
            dec_state_s = dec_state_r;
        end

`ifdef REPEAT_FILTER_EN
        pass_s = !((held_r != 8'h00) && (shift_r == held_r));
`else
        pass_s = 1'b1;
`endif
        emit_s = make_s && (shift_r != 8'h00) && pass_s;
        ctl_s  = is_control(shift_r);
        if (emit_s) begin
            held_s = shift_r;
        end else begin
            held_s = held_s;
        end
    end

    // Decoder state register, Pause skip counter and held-key register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dec_state_r <= D_IDLE;
            skip_r      <= 3'd0;
            held_r      <= 8'h00;
        end else begin
            dec_state_r <= dec_state_s;
            skip_r      <= skip_s;
            held_r      <= held_s;
        end
    end

    // Registered translator strobes and error pulse; idle channel code reads as zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            buton_giris   <= 8'h00;
            buton_aktif   <= 1'b0;
            kontrol_giris <= 8'h00;
            kontrol_aktif <= 1'b0;
            hata          <= 1'b0;
        end else begin
            buton_aktif   <= emit_s && !ctl_s;
            buton_giris   <= (emit_s && !ctl_s) ? shift_r : 8'h00;
            kontrol_aktif <= emit_s && ctl_s;
            kontrol_giris <= (emit_s && ctl_s) ? shift_r : 8'h00;
            hata          <= frame_err_s | timeout_s;
        end
    end

endmodule
